// File: rtl/myimode_cfg_sequencer.sv
// AXI4-Lite master that loads the myImode register bank and reports pass/fail with the first failing index.
// Define MYIMODE_SEQ_READBACK_EN to add the read-back and compare of every written register.

module myimode_cfg_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0000_0000
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,
    input  logic                                      start,
    input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0]  cfg_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      pass,
    output logic [3:0]                                err_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             M_AXI_AWADDR,
    output logic [2:0]                                M_AXI_AWPROT,
    output logic                                      M_AXI_AWVALID,
    input  logic                                      M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]             M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]           M_AXI_WSTRB,
    output logic                                      M_AXI_WVALID,
    input  logic                                      M_AXI_WREADY,
    input  logic [1:0]                                M_AXI_BRESP,
    input  logic                                      M_AXI_BVALID,
    output logic                                      M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             M_AXI_ARADDR,
    output logic [2:0]                                M_AXI_ARPROT,
    output logic                                      M_AXI_ARVALID,
    input  logic                                      M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]             M_AXI_RDATA,
    input  logic [1:0]                                M_AXI_RRESP,
    input  logic                                      M_AXI_RVALID,
    output logic                                      M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

`ifdef MYIMODE_SEQ_READBACK_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_WR = 3'd1, ST_WRESP = 3'd2, ST_RD = 3'd3,
        ST_RDATA = 3'd4, ST_NEXT = 3'd5, ST_DONE = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_WR = 3'd1, ST_WRESP = 3'd2, ST_NEXT = 3'd5, ST_DONE = 3'd6
    } state_t;
`endif

    // Address arithmetic wraps naturally at the address width.
    function automatic logic [AW-1:0] reg_addr(input logic [3:0] i);
        return C_BASE_ADDR + AW'({i, 2'b00});
    endfunction

    function automatic logic [DW-1:0] reg_word(input logic [DW*C_NUM_REGS-1:0] bank, input logic [3:0] i);
        return bank[32'(i) * DW +: DW];
    endfunction

    state_t          state_r, state_nxt_s;
    logic [3:0]      idx_r, idx_nxt_s;
    logic            aw_done_r, aw_done_nxt_s, w_done_r, w_done_nxt_s;
    logic            awvalid_r, awvalid_nxt_s, wvalid_r, wvalid_nxt_s;
    logic            bready_r, bready_nxt_s;
    logic [AW-1:0]   awaddr_r, awaddr_nxt_s;
    logic [DW-1:0]   wdata_r, wdata_nxt_s;
    logic            busy_r, busy_nxt_s, done_r, done_nxt_s, pass_r, pass_nxt_s;
    logic [3:0]      err_idx_r, err_idx_nxt_s;
    logic            aw_hs_s, w_hs_s, b_hs_s;

    assign aw_hs_s = awvalid_r & M_AXI_AWREADY;
    assign w_hs_s  = wvalid_r & M_AXI_WREADY;
    assign b_hs_s  = bready_r & M_AXI_BVALID;

`ifdef MYIMODE_SEQ_READBACK_EN
    logic            arvalid_r, arvalid_nxt_s, rready_r, rready_nxt_s;
    logic [AW-1:0]   araddr_r, araddr_nxt_s;
    logic            ar_hs_s, r_hs_s;
    logic [DW-1:0]   cur_word_s;

    assign ar_hs_s    = arvalid_r & M_AXI_ARREADY;
    assign r_hs_s     = rready_r & M_AXI_RVALID;
    assign cur_word_s = reg_word(cfg_data, idx_r);
`else
    logic            unused_rd_s;
    assign unused_rd_s = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        awvalid_nxt_s = awvalid_r;
        wvalid_nxt_s  = wvalid_r;
        bready_nxt_s  = bready_r;
        awaddr_nxt_s  = awaddr_r;
        wdata_nxt_s   = wdata_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        pass_nxt_s    = pass_r;
        err_idx_nxt_s = err_idx_r;
`ifdef MYIMODE_SEQ_READBACK_EN
        arvalid_nxt_s = arvalid_r;
        rready_nxt_s  = rready_r;
        araddr_nxt_s  = araddr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s   = ST_WR;
                    idx_nxt_s     = 4'd0;
                    pass_nxt_s    = 1'b0;
                    err_idx_nxt_s = 4'd0;
                    busy_nxt_s    = 1'b1;
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                    awaddr_nxt_s  = reg_addr(4'd0);
                    wdata_nxt_s   = reg_word(cfg_data, 4'd0);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // AW and W complete independently; either may finish first.
                if (aw_hs_s) begin
                    awvalid_nxt_s = 1'b0;
                    aw_done_nxt_s = 1'b1;
                end else begin
                    awvalid_nxt_s = awvalid_r;
                end
                if (w_hs_s) begin
                    wvalid_nxt_s = 1'b0;
                    w_done_nxt_s = 1'b1;
                end else begin
                    wvalid_nxt_s = wvalid_r;
                end
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                    state_nxt_s  = ST_WRESP;
                    bready_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    bready_nxt_s = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        state_nxt_s   = ST_DONE;
                        err_idx_nxt_s = idx_r;
                        pass_nxt_s    = 1'b0;
                        busy_nxt_s    = 1'b0;
                        done_nxt_s    = 1'b1;
                    end else begin
`ifdef MYIMODE_SEQ_READBACK_EN
                        state_nxt_s   = ST_RD;
                        arvalid_nxt_s = 1'b1;
                        araddr_nxt_s  = reg_addr(idx_r);
`else
                        state_nxt_s   = ST_NEXT;
`endif
                    end
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
`ifdef MYIMODE_SEQ_READBACK_EN
            ST_RD: begin
                if (ar_hs_s) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_RDATA;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RDATA: begin
                if (r_hs_s) begin
                    rready_nxt_s = 1'b0;
                    if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != cur_word_s)) begin
                        state_nxt_s   = ST_DONE;
                        err_idx_nxt_s = idx_r;
                        pass_nxt_s    = 1'b0;
                        busy_nxt_s    = 1'b0;
                        done_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_NEXT;
                    end
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
`endif
            ST_NEXT: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                    pass_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s   = ST_WR;
                    idx_nxt_s     = idx_r + 4'd1;
                    awvalid_nxt_s = 1'b1;
                    wvalid_nxt_s  = 1'b1;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                    awaddr_nxt_s  = reg_addr(idx_r + 4'd1);
                    wdata_nxt_s   = reg_word(cfg_data, idx_r + 4'd1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                busy_nxt_s    = 1'b0;
                awvalid_nxt_s = 1'b0;
                wvalid_nxt_s  = 1'b0;
                bready_nxt_s  = 1'b0;
`ifdef MYIMODE_SEQ_READBACK_EN
                arvalid_nxt_s = 1'b0;
                rready_nxt_s  = 1'b0;
`endif
            end
        endcase
    end

    // State and registered-output update; reset clears every output immediately.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_idx_r <= 4'd0;
`ifdef MYIMODE_SEQ_READBACK_EN
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            araddr_r  <= '0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            awvalid_r <= awvalid_nxt_s;
            wvalid_r  <= wvalid_nxt_s;
            bready_r  <= bready_nxt_s;
            awaddr_r  <= awaddr_nxt_s;
            wdata_r   <= wdata_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
            err_idx_r <= err_idx_nxt_s;
`ifdef MYIMODE_SEQ_READBACK_EN
            arvalid_r <= arvalid_nxt_s;
            rready_r  <= rready_nxt_s;
            araddr_r  <= araddr_nxt_s;
`endif
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_idx       = err_idx_r;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = {(DW/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARPROT  = 3'b000;
`ifdef MYIMODE_SEQ_READBACK_EN
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;
`else
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_myimode_cfg_sequencer.sv
// Randomized bench for myimode_cfg_sequencer: a delay/fault-injecting AXI4-Lite slave plus a
// transaction-level model of the expected writes, reads, result and zero-wait latency.

module tb_myimode_cfg_sequencer;

    localparam int N = 4;
`ifdef MYIMODE_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int P = RB ? 5 : 3;

    logic         tb_ACLK = 1'b0;
    logic         arstn;
    logic         start;
    logic [127:0] cfg_data;
    logic         busy, done, pass;
    logic [3:0]   err_idx;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    always #5 tb_ACLK = ~tb_ACLK;

    myimode_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .C_NUM_REGS(N), .C_BASE_ADDR(32'h0000_0000)
    ) dut (
        .ACLK(tb_ACLK), .ARESETN(arstn), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .pass(pass), .err_idx(err_idx),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave configuration: per-channel wait cycles and fault injection (1 = BRESP error, 2 = corrupt RDATA).
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int fault_mode = 0, fault_idx = 0;

    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          got_aw, got_w, b_pend, r_pend;
    logic [31:0] cur_addr, cur_data, r_addr;
    logic [31:0] mem [16];
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    logic [3:0]  wr_strb_q[$];
    int          ar_cycles = 0, viol = 0, prot_bad = 0;
    bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic        aw_hs, w_hs;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign bvalid  = b_pend && (b_cnt == 0);
    assign bresp   = (fault_mode == 1 && int'(cur_addr[5:2]) == fault_idx) ? 2'b10 : 2'b00;
    assign rvalid  = r_pend && (r_cnt == 0);
    assign rresp   = 2'b00;
    assign rdata   = mem[r_addr[5:2]] ^ ((fault_mode == 2 && int'(r_addr[5:2]) == fault_idx) ? 32'h1 : 32'h0);

    // Reactive slave: logs every handshake and counts VALID/payload stability violations.
    always @(posedge tb_ACLK or negedge arstn) begin
        if (!arstn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                got_aw <= 1'b1; cur_addr <= awaddr; wr_addr_q.push_back(awaddr);
                if (awprot != 3'b000) prot_bad <= prot_bad + 1;
            end
            if (w_hs) begin
                got_w <= 1'b1; cur_data <= wdata; wr_data_q.push_back(wdata); wr_strb_q.push_back(wstrb);
            end
            if ((got_aw || aw_hs) && (got_w || w_hs) && !b_pend) begin
                b_pend <= 1'b1; b_cnt <= b_dly;
                mem[aw_hs ? awaddr[5:2] : cur_addr[5:2]] <= w_hs ? wdata : cur_data;
            end else if (b_pend && b_cnt != 0) begin
                b_cnt <= b_cnt - 1;
            end
            if (bvalid && bready) begin
                b_pend <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_cnt <= r_dly; r_addr <= araddr; rd_addr_q.push_back(araddr);
                if (arprot != 3'b000) prot_bad <= prot_bad + 1;
            end else if (r_pend && r_cnt != 0) begin
                r_cnt <= r_cnt - 1;
            end
            if (rvalid && rready) r_pend <= 1'b0;
            if (arvalid) ar_cycles <= ar_cycles + 1;
            viol <= viol + int'(p_awv && !p_awr && (!awvalid || awaddr != p_awaddr))
                         + int'(p_wv && !p_wr && (!wvalid || wdata != p_wdata))
                         + int'(p_arv && !p_arr && (!arvalid || araddr != p_araddr));
            p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
            p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
            p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete sequence; dly_sel 0 = zero-wait, 1 = random waits, 2 = AW 3 / W 1 wait cycles.
    task automatic run_seq(input logic [127:0] words, input int mode, input int k,
                           input int dly_sel, input bit extra_start);
        int wb, rbq, arb, vb, pb, c, nw, nr, lat, nchk;
        bit exp_pass;
        logic [3:0] exp_err;
        cfg_data   = words;
        fault_mode = mode;
        fault_idx  = k;
        if (dly_sel == 0) begin
            aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        end else if (dly_sel == 2) begin
            aw_dly = 3; w_dly = 1; b_dly = 0; ar_dly = 0; r_dly = 0;
        end else begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
        end
        wb = wr_addr_q.size(); rbq = rd_addr_q.size(); arb = ar_cycles; vb = viol; pb = prot_bad;

        // Expected outcome from the sequence rules: register i is written, then (with readback) read.
        if (mode == 1) begin
            nw = k + 1; nr = RB ? k : 0; exp_pass = 1'b0; exp_err = 4'(k); lat = P * k + 3;
        end else if (mode == 2 && RB) begin
            nw = k + 1; nr = k + 1; exp_pass = 1'b0; exp_err = 4'(k); lat = P * k + 5;
        end else begin
            nw = N; nr = RB ? N : 0; exp_pass = 1'b1; exp_err = 4'd0; lat = P * N + 1;
        end

        @(negedge tb_ACLK) start = 1'b1;
        @(negedge tb_ACLK) start = 1'b0;
        check_value("busy_t1", busy, 1);
        check_value("awvalid_t1", awvalid, 1);
        check_value("wvalid_t1", wvalid, 1);
        check_value("awaddr_t1", awaddr, 0);
        c = 1;
        while (!done && c < 3000) begin
            if (extra_start && c == 3) start = 1'b1;
            else start = 1'b0;
            @(negedge tb_ACLK);
            c++;
        end
        start = 1'b0;
        check_value("done_seen", done, 1);
        if (dly_sel == 0) check_value("done_latency", c, lat);
        check_value("busy_at_done", busy, 0);
        check_value("pass", pass, exp_pass);
        check_value("err_idx", err_idx, exp_err);
        @(negedge tb_ACLK);
        check_value("done_pulse", done, 0);
        check_value("pass_hold", pass, exp_pass);
        repeat (4) @(negedge tb_ACLK);

        check_value("n_writes", wr_addr_q.size() - wb, nw);
        check_value("n_wdata", wr_data_q.size() - wb, nw);
        nchk = (wr_addr_q.size() - wb < nw) ? wr_addr_q.size() - wb : nw;
        for (int i = 0; i < nchk; i++) begin
            check_value("wr_addr", wr_addr_q[wb + i], 4 * i);
            check_value("wr_data", wr_data_q[wb + i], words[32 * i +: 32]);
            check_value("wr_strb", wr_strb_q[wb + i], 4'hF);
        end
        check_value("n_reads", rd_addr_q.size() - rbq, nr);
        nchk = (rd_addr_q.size() - rbq < nr) ? rd_addr_q.size() - rbq : nr;
        for (int i = 0; i < nchk; i++) check_value("rd_addr", rd_addr_q[rbq + i], 4 * i);
        check_value("arvalid_activity", (ar_cycles - arb) != 0, nr != 0);
        check_value("valid_stability", viol - vb, 0);
        check_value("prot_zero", prot_bad - pb, 0);
    endtask

    // Reset asserted while register 1 waits in the write-response phase.
    task automatic reset_mid_wresp();
        int wb, c;
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
        fault_mode = 0;
        aw_dly = 0; w_dly = 0; b_dly = 4; ar_dly = 0; r_dly = 0;
        wb = wr_addr_q.size();
        @(negedge tb_ACLK) start = 1'b1;
        @(negedge tb_ACLK) start = 1'b0;
        c = 0;
        while (!(bready && (wr_addr_q.size() - wb) == 2) && c < 500) begin
            @(negedge tb_ACLK);
            c++;
        end
        check_value("reach_wresp1", bready && (wr_addr_q.size() - wb) == 2, 1);
        arstn = 1'b0;
        #1;
        check_value("rst_awvalid", awvalid, 0);
        check_value("rst_wvalid", wvalid, 0);
        check_value("rst_bready", bready, 0);
        check_value("rst_arvalid", arvalid, 0);
        check_value("rst_rready", rready, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_awaddr", awaddr, 0);
        check_value("rst_pass", pass, 0);
        @(negedge tb_ACLK) arstn = 1'b1;
        b_dly = 0;
        repeat (2) @(negedge tb_ACLK);
        check_value("post_rst_busy", busy, 0);
    endtask

    initial begin
        arstn = 1'b0;
        start = 1'b0;
        cfg_data = '0;
        repeat (3) @(negedge tb_ACLK);
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_pass", pass, 0);
        check_value("reset_err_idx", err_idx, 0);
        check_value("reset_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check_value("reset_awaddr", awaddr, 0);
        check_value("reset_araddr", araddr, 0);
        check_value("reset_wdata", wdata, 0);
        arstn = 1'b1;
        repeat (2) @(negedge tb_ACLK);

        run_seq({32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF}, 0, 0, 0, 1'b0);
        run_seq({32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF}, 0, 0, 2, 1'b0);
        run_seq({32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF}, 1, 2, 0, 1'b0);
        run_seq({32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF}, 2, 1, 0, 1'b0);
        reset_mid_wresp();
        run_seq({32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888}, 0, 0, 0, 1'b0);
        run_seq({32'hcafe_0003, 32'hcafe_0002, 32'hcafe_0001, 32'hcafe_0000}, 0, 0, 0, 1'b1);
        for (int r = 0; r < 24; r++) begin
            run_seq({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2),
                    $urandom_range(0, N - 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
